// File: rtl/uart_frame_rx_pkg.sv
// Shared constants and state encoding for the UART frame receiver.
// Frame geometry matches the PC-bound frame sender.
package uart_frame_rx_pkg;

   localparam int FRAME_BYTES = 5;
   localparam int FRAME_W     = 8 * FRAME_BYTES;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

endpackage

// File: rtl/uart_frame_timer.sv
// Idle-gap timer: counts enabled cycles since the last clear.
// expire is a combinational pulse on the enabled cycle whose increment would reach TIMEOUT_CYCLES-1.
module uart_frame_timer #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W          = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 2);

   logic [CNT_W-1:0] count;

   assign expire = enable && !clear && (count == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear || expire) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_frame_rx.sv
// Reassembles fixed-size command frames from a UART byte stream, first byte MSB-first.
// Completed frames sit in a holding register offered via valid/ready.
module uart_frame_rx
   import uart_frame_rx_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W          = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         rx_byte,
   input  logic               rx_valid,
   output logic [FRAME_W-1:0] frame_data,
   output logic               frame_valid,
   input  logic               frame_ready,
   output logic [2:0]         byte_cnt,
   output logic               timeout_err,
   output logic               overflow
);

   // Handshake: a frame transfers on any rising clk edge where frame_valid & frame_ready;
   // frame_valid/frame_data hold steady until then, independent of frame_ready.

   localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

   state_t             state, state_n;
   logic [FRAME_W-1:0] shift_reg, shift_n, shifted;
   logic [2:0]         cnt_n;
   logic               complete, tmo_n;
   logic               t_clear, t_en, t_expire;
   logic               consume;

   uart_frame_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (t_clear),
      .enable(t_en),
      .expire(t_expire)
   );

   assign shifted = {shift_reg[FRAME_W-9:0], rx_byte};
   assign consume = frame_valid && frame_ready;

   always_comb begin
      state_n  = state;
      shift_n  = shift_reg;
      cnt_n    = byte_cnt;
      complete = 1'b0;
      tmo_n    = 1'b0;
      t_clear  = 1'b0;
      t_en     = 1'b0;
      unique case (state)
         IDLE: begin
            if (rx_valid) begin
               shift_n = shifted;
               cnt_n   = 3'd1;
               t_clear = 1'b1;
               state_n = COLLECT;
            end
         end
         COLLECT: begin
            if (rx_valid) begin
               t_clear = 1'b1;
               if (byte_cnt == LAST_IDX) begin
                  complete = 1'b1;
                  shift_n  = '0;
                  cnt_n    = 3'd0;
                  state_n  = IDLE;
               end else begin
                  shift_n = shifted;
                  cnt_n   = byte_cnt + 3'd1;
               end
            end else begin
               t_en = 1'b1;
               if (t_expire) begin
                  shift_n = '0;
                  cnt_n   = 3'd0;
                  tmo_n   = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         shift_reg   <= '0;
         byte_cnt    <= 3'd0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         shift_reg   <= shift_n;
         byte_cnt    <= cnt_n;
         timeout_err <= tmo_n;
      end
   end

   // A frame completing while the held one leaves this same cycle loads with no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_data  <= '0;
         frame_valid <= 1'b0;
         overflow    <= 1'b0;
      end else if (complete) begin
         if (!frame_valid || consume) begin
            frame_data  <= shifted;
            frame_valid <= 1'b1;
         end else begin
            overflow <= 1'b1;
         end
      end else if (consume) begin
         frame_valid <= 1'b0;
      end
   end

endmodule
